usb_token_controller: RTL and testbench



---
 rtl/usb_token_controller_pkg.sv | 53 +++++
 rtl/usb_token_controller_crc5.sv | 14 +
 rtl/usb_token_controller.sv | 159 +++++++++++++++
 tb/tb_usb_token_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usb_token_controller_pkg.sv
// Shared types and CRC5 helper for the USB token decoder.
// The CRC5 function is also used by the bench to build stimulus.
package usb_token_controller_pkg;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } d_port_t;

    typedef enum logic [3:0] {
        RESERVED = 4'b0000,
        OUT      = 4'b0001,
        IN       = 4'b1001,
        SOF      = 4'b0101,
        SETUP    = 4'b1101,
        DATA0    = 4'b0011,
        DATA1    = 4'b1011,
        ACK      = 4'b0010,
        NAK      = 4'b1010,
        STALL    = 4'b1110
    } pid_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CRC,
        EOP_WAIT,
        SKIP,
        LINE_IDLE
    } tok_state_t;

    // Serial CRC5 over {endp, addr}, bit 0 first; result already inverted.
    function automatic logic [4:0] crc5(input logic [10:0] d);
        logic [4:0] c;
        c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ d[i])
                c = (c >> 1) ^ 5'b10100;
            else
                c = c >> 1;
        end
        return ~c;
    endfunction

    function automatic logic is_token_pid(input logic [7:0] b);
        logic good;
        good = (b[7:4] == ~b[3:0]);
        return good && (b[3:0] == OUT || b[3:0] == IN || b[3:0] == SETUP);
    endfunction

endpackage

// File: rtl/usb_token_controller_crc5.sv
// Combinational CRC5 for token packets.
// Only built when USB_TOKEN_CRC5_CHECK_EN is defined.
`ifdef USB_TOKEN_CRC5_CHECK_EN
module usb_crc5
    import usb_token_controller_pkg::*;
(
    input  logic [10:0] data_i,
    output logic [4:0]  crc_o
);

    assign crc_o = crc5(data_i);

endmodule
`endif

// File: rtl/usb_token_controller.sv
// Low-speed USB receive-side token decoder (PID/ADDR/ENDP/CRC5).
// Define USB_TOKEN_CRC5_CHECK_EN to gate acceptance on the CRC5 field.
module usb_token_controller
    import usb_token_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  d_port_t    line_state,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_active,
    input  logic       rx_valid,
    input  logic       rx_error,
    output pid_t       pid,
    output logic [6:0] address,
    output logic [3:0] end_point,
    output logic       token_valid
);

    tok_state_t state_q, state_d;
    pid_t       pid_cap_q, pid_cap_d;
    logic [6:0] addr_cap_q, addr_cap_d;
    logic [3:0] endp_cap_q, endp_cap_d;
    pid_t       pid_q, pid_d;
    logic [6:0] address_q, address_d;
    logic [3:0] endp_q, endp_d;
    logic       tv_q, tv_d;
    logic       se0;
    logic       crc_ok;
    logic       unused_tx_ready;

    assign unused_tx_ready = tx_ready;
    assign se0 = (line_state == SE0);

`ifdef USB_TOKEN_CRC5_CHECK_EN
    logic [4:0] crc_cap_q, crc_cap_d;
    logic [4:0] crc_calc;

    usb_crc5 u_crc5 (
        .data_i ({endp_cap_q, addr_cap_q}),
        .crc_o  (crc_calc)
    );

    assign crc_ok = (crc_calc == crc_cap_q);

    always_ff @(posedge clk) begin
        if (reset) crc_cap_q <= '0;
        else       crc_cap_q <= crc_cap_d;
    end
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        pid_cap_d  = pid_cap_q;
        addr_cap_d = addr_cap_q;
        endp_cap_d = endp_cap_q;
        pid_d      = pid_q;
        address_d  = address_q;
        endp_d     = endp_q;
        tv_d       = 1'b0;
`ifdef USB_TOKEN_CRC5_CHECK_EN
        crc_cap_d  = crc_cap_q;
`endif
        if (rx_error) begin
            state_d = SKIP;
        end else if (!rx_active &&
                     (state_q == ADDR || state_q == CRC ||
                      state_q == EOP_WAIT)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (is_token_pid(rx_data)) begin
                            pid_cap_d = pid_t'(rx_data[3:0]);
                            state_d   = ADDR;
                        end else begin
                            state_d = SKIP;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr_cap_d    = rx_data[6:0];
                        endp_cap_d[0] = rx_data[7];
                        state_d       = CRC;
                    end else if (se0) begin
                        state_d = LINE_IDLE;
                    end
                end
                CRC: begin
                    if (rx_valid) begin
                        endp_cap_d[3:1] = rx_data[2:0];
`ifdef USB_TOKEN_CRC5_CHECK_EN
                        crc_cap_d = rx_data[7:3];
`endif
                        state_d = EOP_WAIT;
                    end else if (se0) begin
                        state_d = LINE_IDLE;
                    end
                end
                EOP_WAIT: begin
                    if (rx_valid) begin
                        state_d = SKIP;
                    end else if (se0) begin
                        if (crc_ok) begin
                            tv_d      = 1'b1;
                            pid_d     = pid_cap_q;
                            address_d = addr_cap_q;
                            endp_d    = endp_cap_q;
                        end
                        state_d = LINE_IDLE;
                    end
                end
                SKIP: begin
                    if (se0) state_d = LINE_IDLE;
                end
                LINE_IDLE: begin
                    if (!se0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pid_cap_q  <= RESERVED;
            addr_cap_q <= '0;
            endp_cap_q <= '0;
            pid_q      <= RESERVED;
            address_q  <= '0;
            endp_q     <= '0;
            tv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_cap_q  <= pid_cap_d;
            addr_cap_q <= addr_cap_d;
            endp_cap_q <= endp_cap_d;
            pid_q      <= pid_d;
            address_q  <= address_d;
            endp_q     <= endp_d;
            tv_q       <= tv_d;
        end
    end

    assign tx_data     = 8'h00;
    assign tx_valid    = 1'b0;
    assign pid         = pid_q;
    assign address     = address_q;
    assign end_point   = endp_q;
    assign token_valid = tv_q;

endmodule

// File: tb/tb_usb_token_controller.sv
// Directed self-checking bench for usb_token_controller.
// Expected CRC5 fields are hand-computed constants.
module tb_usb_token_controller;
    import usb_token_controller_pkg::*;

    logic       clk;
    logic       reset;
    d_port_t    line_state;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_active;
    logic       rx_valid;
    logic       rx_error;
    pid_t       pid;
    logic [6:0] address;
    logic [3:0] end_point;
    logic       token_valid;

    int checks;
    int errors;
    int pulses;

    usb_token_controller dut (
        .clk         (clk),
        .reset       (reset),
        .line_state  (line_state),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_active   (rx_active),
        .rx_valid    (rx_valid),
        .rx_error    (rx_error),
        .pid         (pid),
        .address     (address),
        .end_point   (end_point),
        .token_valid (token_valid)
    );

    initial begin
        clk = 1'b0;
        forever #21 clk = ~clk;
    end

    always @(negedge clk) begin
        if (token_valid) pulses++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic eop(input int n, output logic first);
        @(negedge clk);
        line_state = SE0;
        @(negedge clk);
        first = token_valid;
        repeat (n - 1) @(negedge clk);
        line_state = J;
        repeat (3) @(negedge clk);
    endtask

    task automatic pkt(input string tag, input int nb,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input int n_se0, input int exp);
        int   p0;
        logic first;
        p0 = pulses;
        rx_active = 1'b1;
        if (nb > 0) put(b0);
        if (nb > 1) put(b1);
        if (nb > 2) put(b2);
        if (nb > 3) put(b3);
        eop(n_se0, first);
        check({tag, "_first"}, {31'd0, first}, exp);
        check({tag, "_cnt"}, pulses - p0, exp);
    endtask

    task automatic outs(input string tag, input logic [3:0] p,
                        input logic [6:0] a, input logic [3:0] e);
        check({tag, "_pid"}, {28'd0, pid}, {28'd0, p});
        check({tag, "_addr"}, {25'd0, address}, {25'd0, a});
        check({tag, "_endp"}, {28'd0, end_point}, {28'd0, e});
    endtask

    initial begin
        int   p0;
        logic first;
        checks     = 0;
        errors     = 0;
        pulses     = 0;
        reset      = 1'b1;
        line_state = J;
        tx_ready   = 1'b0;
        rx_data    = 8'h00;
        rx_active  = 1'b0;
        rx_valid   = 1'b0;
        rx_error   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tv", {31'd0, token_valid}, 32'd0);
        check("rst_txd", {24'd0, tx_data}, 32'd0);
        check("rst_txv", {31'd0, tx_valid}, 32'd0);
        outs("rst", 4'h0, 7'h00, 4'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("crc_setup", {27'd0, crc5({4'hE, 7'h15})}, 32'h1D);
        check("crc_out", {27'd0, crc5({4'hA, 7'h3A})}, 32'h07);
        check("crc_in", {27'd0, crc5({4'h4, 7'h70})}, 32'h0E);
        check("crc_zero", {27'd0, crc5(11'h000)}, 32'h02);

        pkt("setup", 3, 8'h2D, 8'h15, 8'hEF, 8'h00, 32, 1);
        outs("setup", 4'hD, 7'h15, 4'hE);
        rx_active = 1'b0;
        repeat (2) @(negedge clk);

        pkt("b2b_out", 3, 8'hE1, 8'h3A, 8'h3D, 8'h00, 4, 1);
        outs("b2b_out", 4'h1, 7'h3A, 4'hA);
        pkt("b2b_in", 3, 8'h69, 8'h70, 8'h72, 8'h00, 4, 1);
        outs("b2b_in", 4'h9, 7'h70, 4'h4);
        rx_active = 1'b0;
        repeat (2) @(negedge clk);

`ifdef USB_TOKEN_CRC5_CHECK_EN
        pkt("badcrc", 3, 8'h2D, 8'h15, 8'hE7, 8'h00, 4, 0);
        outs("badcrc", 4'h9, 7'h70, 4'h4);
`else
        pkt("nocrc", 3, 8'h2D, 8'h15, 8'hE7, 8'h00, 4, 1);
        outs("nocrc", 4'hD, 7'h15, 4'hE);
`endif
        pkt("badpid", 3, 8'h21, 8'h3A, 8'h3D, 8'h00, 4, 0);
`ifdef USB_TOKEN_CRC5_CHECK_EN
        outs("badpid", 4'h9, 7'h70, 4'h4);
`else
        outs("badpid", 4'hD, 7'h15, 4'hE);
`endif

        p0 = pulses;
        put(8'h69);
        put(8'h3A);
        @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        put(8'h72);
        eop(4, first);
        check("rxerr_first", {31'd0, first}, 32'd0);
        check("rxerr_cnt", pulses - p0, 32'd0);
        pkt("after_err", 3, 8'hE1, 8'h3A, 8'h3D, 8'h00, 4, 1);
        outs("after_err", 4'h1, 7'h3A, 4'hA);

        pkt("data0", 3, 8'hC3, 8'h12, 8'h34, 8'h00, 4, 0);
        pkt("toolong", 4, 8'h69, 8'h70, 8'h72, 8'h55, 4, 0);
        pkt("trunc", 2, 8'h69, 8'h70, 8'h00, 8'h00, 4, 0);
        outs("hold", 4'h1, 7'h3A, 4'hA);

        p0 = pulses;
        put(8'h69);
        put(8'h70);
        put(8'h72);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        eop(4, first);
        check("rstmid_first", {31'd0, first}, 32'd0);
        check("rstmid_cnt", pulses - p0, 32'd0);
        outs("rstmid", 4'h0, 7'h00, 4'h0);
        rx_active = 1'b0;
        repeat (2) @(negedge clk);

        pkt("post_rst", 3, 8'h2D, 8'h15, 8'hEF, 8'h00, 4, 1);
        outs("post_rst", 4'hD, 7'h15, 4'hE);
        rx_active = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
